// File: rtl/eco32f_pkg.sv
// rtl/eco32f_pkg.sv - shared eco32f writeback constants and types
package eco32f_pkg;

  localparam int DATA_W       = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int EXC_LINK_REG = 30;

  // Which source owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_EXC,
    WB_MAIN,
    WB_LATE
  } wb_src_e;

endpackage

// File: rtl/eco32f_writeback_arb_if.sv
// rtl/eco32f_writeback_arb_if.sv - memory-stage, late-result and register-file signals of the writeback stage
interface eco32f_writeback_arb_if #(
  parameter int DATA_W  = eco32f_pkg::DATA_W,
  parameter int ADDR_W  = eco32f_pkg::REG_ADDR_W,
  parameter int LATE_CH = 2,
  parameter int CNT_W   = 32
);

  // Memory-stage side
  logic                      do_exception;
  logic                      mem_stall;
  logic [DATA_W-1:0]         mem_pc;
  logic [DATA_W-1:0]         mem_alu_result;
  logic [DATA_W-1:0]         mem_lsu_result;
  logic                      mem_op_load;
  logic                      mem_rf_r_we;
  logic [ADDR_W-1:0]         mem_rf_r_addr;

  // Late-completing units (mul, div, ...)
  logic [LATE_CH-1:0]        late_valid;
  logic [LATE_CH*DATA_W-1:0] late_data;
  logic [LATE_CH*ADDR_W-1:0] late_addr;
  logic [LATE_CH-1:0]        late_ready;

  // Register-file write port and status
  logic [DATA_W-1:0]         wb_rf_r;
  logic                      wb_rf_r_we;
  logic [ADDR_W-1:0]         wb_rf_r_addr;
  logic                      wb_late_busy;
  logic [CNT_W-1:0]          wb_retired;

  // Pipeline / late-unit side that drives the stage
  modport master (
    output do_exception, mem_stall, mem_pc, mem_alu_result, mem_lsu_result,
    output mem_op_load, mem_rf_r_we, mem_rf_r_addr,
    output late_valid, late_data, late_addr,
    input  late_ready,
    input  wb_rf_r, wb_rf_r_we, wb_rf_r_addr, wb_late_busy, wb_retired
  );

  // The writeback stage itself
  modport slave (
    input  do_exception, mem_stall, mem_pc, mem_alu_result, mem_lsu_result,
    input  mem_op_load, mem_rf_r_we, mem_rf_r_addr,
    input  late_valid, late_data, late_addr,
    output late_ready,
    output wb_rf_r, wb_rf_r_we, wb_rf_r_addr, wb_late_busy, wb_retired
  );

endinterface

// File: rtl/eco32f_wb_fifo.sv
// rtl/eco32f_wb_fifo.sv - small circular FIFO buffering late writeback results
module eco32f_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // Flush wins over both ports; full/empty come from the registered count only.
  assign do_push = push & ~flush & ~full;
  assign do_pop  = pop  & ~flush & ~empty;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/eco32f_writeback_arb.sv
// rtl/eco32f_writeback_arb.sv - shared register-file write port for main pipeline and late units
module eco32f_writeback_arb #(
  parameter int DATA_W  = eco32f_pkg::DATA_W,
  parameter int ADDR_W  = eco32f_pkg::REG_ADDR_W,
  parameter int LATE_CH = 2,
  parameter int QDEPTH  = 4,
  parameter int EXC_REG = eco32f_pkg::EXC_LINK_REG,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  eco32f_writeback_arb_if.slave bus
);

  import eco32f_pkg::*;

  localparam int PTR_W  = (LATE_CH > 1) ? $clog2(LATE_CH) : 1;
  localparam int ENT_W  = ADDR_W + DATA_W;
  localparam int QCNT_W = $clog2(QDEPTH) + 1;

  logic                advance;
  logic                main_we;
  logic [DATA_W-1:0]   main_data;

  logic                grant_any;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                accept;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   sel_data;
  logic [ADDR_W-1:0]   sel_addr;

  logic [ENT_W-1:0]    fifo_din, fifo_dout;
  logic [QCNT_W-1:0]   fifo_count;
  logic                fifo_full, fifo_empty;

  wb_src_e             src;

  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic                wb_we_q, wb_we_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  // An exception always pushes the memory-stage slot forward, even when stalled.
  assign advance   = ~bus.mem_stall | bus.do_exception;
  assign main_we   = bus.do_exception |
                     (advance & bus.mem_rf_r_we & (bus.mem_rf_r_addr != '0));
  assign main_data = bus.mem_op_load ? bus.mem_lsu_result : bus.mem_alu_result;

  // Round-robin pick: search starts at rr_ptr_q (one past the last accepted channel).
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < LATE_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= LATE_CH) idx = idx - LATE_CH;
      if (!grant_any && bus.late_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  assign sel_data = bus.late_data[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_addr = bus.late_addr[int'(grant_idx)*ADDR_W +: ADDR_W];

  // No pop-through: a full FIFO refuses even if it pops this same edge.
  assign accept = grant_any & ~fifo_full & ~bus.do_exception;
  // r0 results complete the handshake but are dropped instead of stored.
  assign push   = accept & (sel_addr != '0);

  // One-hot ready to the granted channel only.
  always_comb begin
    bus.late_ready = '0;
    for (int i = 0; i < LATE_CH; i++) begin
      bus.late_ready[i] = accept && (int'(grant_idx) == i);
    end
  end

  // Advance the round-robin pointer past the channel whose handshake completed.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (int'(grant_idx) == LATE_CH - 1) rr_ptr_d = '0;
      else                                rr_ptr_d = grant_idx + PTR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign fifo_din = {sel_addr, sel_data};

  eco32f_wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.do_exception),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Port owner this cycle: exception, then main pipeline, then buffered late result.
  always_comb begin
    src = WB_NONE;
    if (bus.do_exception)  src = WB_EXC;
    else if (main_we)      src = WB_MAIN;
    else if (!fifo_empty)  src = WB_LATE;
  end

  assign pop = (src == WB_LATE);

  // Next write-port values; data and address hold when the port is idle.
  always_comb begin
    wb_we_d   = 1'b0;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    case (src)
      WB_EXC: begin
        wb_we_d   = 1'b1;
        wb_data_d = bus.mem_pc;
        wb_addr_d = ADDR_W'(EXC_REG);
      end
      WB_MAIN: begin
        wb_we_d   = 1'b1;
        wb_data_d = main_data;
        wb_addr_d = bus.mem_rf_r_addr;
      end
      WB_LATE: begin
        wb_we_d   = 1'b1;
        wb_data_d = fifo_dout[DATA_W-1:0];
        wb_addr_d = fifo_dout[ENT_W-1:DATA_W];
      end
      default: begin
        wb_we_d = 1'b0;
      end
    endcase
  end

  // Retire count covers main-pipeline instructions leaving normally, not exceptions.
  assign retired_d = (advance & ~bus.do_exception) ? retired_q + CNT_W'(1) : retired_q;

  // Registered write port and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      retired_q <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      retired_q <= retired_d;
    end
  end

  assign bus.wb_rf_r      = wb_data_q;
  assign bus.wb_rf_r_we   = wb_we_q;
  assign bus.wb_rf_r_addr = wb_addr_q;
  assign bus.wb_retired   = retired_q;
  assign bus.wb_late_busy = (fifo_count != '0);

endmodule

// File: tb/tb_eco32f_writeback_arb.sv
// tb/tb_eco32f_writeback_arb.sv - directed self-checking bench for eco32f_writeback_arb
module tb_eco32f_writeback_arb;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ret  = 0;

  eco32f_writeback_arb_if #(
    .DATA_W (32), .ADDR_W (5), .LATE_CH (2), .CNT_W (32)
  ) bus_if ();

  eco32f_writeback_arb #(
    .DATA_W (32), .ADDR_W (5), .LATE_CH (2), .QDEPTH (4), .EXC_REG (30), .CNT_W (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Count the retirement the coming edge should cause, then sample 1 ns after it.
  task automatic step();
    if (!bus_if.mem_stall && !bus_if.do_exception) exp_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_late(input int ch, input logic v, input logic [4:0] a, input logic [31:0] d);
    bus_if.late_valid[ch]        = v;
    bus_if.late_addr[ch*5 +: 5]  = a;
    bus_if.late_data[ch*32 +: 32] = d;
  endtask

  task automatic set_main(input logic stall, input logic we, input logic [4:0] a,
                          input logic ld, input logic [31:0] alu, input logic [31:0] lsu);
    bus_if.mem_stall      = stall;
    bus_if.mem_rf_r_we    = we;
    bus_if.mem_rf_r_addr  = a;
    bus_if.mem_op_load    = ld;
    bus_if.mem_alu_result = alu;
    bus_if.mem_lsu_result = lsu;
  endtask

  initial begin
    int k;
    int j;
    logic rdy;

    rst = 1'b1;
    bus_if.do_exception = 1'b0;
    bus_if.mem_pc       = '0;
    bus_if.late_valid   = '0;
    bus_if.late_data    = '0;
    bus_if.late_addr    = '0;
    set_main(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_we",      bus_if.wb_rf_r_we,   0);
    check_eq("rst_data",    bus_if.wb_rf_r,      0);
    check_eq("rst_addr",    bus_if.wb_rf_r_addr, 0);
    check_eq("rst_retired", bus_if.wb_retired,   0);
    check_eq("rst_busy",    bus_if.wb_late_busy, 0);

    // Main ALU write r5 = 0x1234
    set_main(1'b0, 1'b1, 5'd5, 1'b0, 32'h1234, 32'h0);
    step();
    check_eq("alu_we",      bus_if.wb_rf_r_we,   1);
    check_eq("alu_addr",    bus_if.wb_rf_r_addr, 5);
    check_eq("alu_data",    bus_if.wb_rf_r,      32'h1234);
    check_eq("alu_retired", bus_if.wb_retired,   1);

    // Load to r7 stalled three cycles: single pulse after the stall drops
    set_main(1'b1, 1'b1, 5'd7, 1'b1, 32'h5555, 32'hDEADBEEF);
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("stall_no_we", bus_if.wb_rf_r_we, 0);
    end
    bus_if.mem_stall = 1'b0;
    step();
    check_eq("load_we",      bus_if.wb_rf_r_we,   1);
    check_eq("load_addr",    bus_if.wb_rf_r_addr, 7);
    check_eq("load_data",    bus_if.wb_rf_r,      32'hDEADBEEF);
    check_eq("load_retired", bus_if.wb_retired,   2);
    set_main(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    step();
    check_eq("idle_we",   bus_if.wb_rf_r_we, 0);
    check_eq("idle_hold", bus_if.wb_rf_r,    32'hDEADBEEF);

    // Two late channels at once: ch0 then ch1
    set_late(0, 1'b1, 5'd3, 32'hA);
    set_late(1, 1'b1, 5'd4, 32'hB);
    #1 check_eq("rr_ready_ch0", bus_if.late_ready, 2'b01);
    step();
    set_late(0, 1'b0, 5'd0, 32'h0);
    #1 check_eq("rr_ready_ch1", bus_if.late_ready, 2'b10);
    check_eq("rr_first_we", bus_if.wb_rf_r_we,   0);
    check_eq("rr_busy",     bus_if.wb_late_busy, 1);
    step();
    set_late(1, 1'b0, 5'd0, 32'h0);
    check_eq("rr_w0_we",   bus_if.wb_rf_r_we,   1);
    check_eq("rr_w0_addr", bus_if.wb_rf_r_addr, 3);
    check_eq("rr_w0_data", bus_if.wb_rf_r,      32'hA);
    step();
    check_eq("rr_w1_we",   bus_if.wb_rf_r_we,   1);
    check_eq("rr_w1_addr", bus_if.wb_rf_r_addr, 4);
    check_eq("rr_w1_data", bus_if.wb_rf_r,      32'hB);
    step();
    check_eq("rr_done_we",   bus_if.wb_rf_r_we,   0);
    check_eq("rr_done_busy", bus_if.wb_late_busy, 0);

    // Main busy every cycle while five late results arrive on ch0
    k = 0;
    for (int c = 0; c < 6; c++) begin
      set_main(1'b0, 1'b1, 5'd9, 1'b0, 32'h100 + c, 32'h0);
      set_late(0, k < 5, 5'(10 + k), 32'h50 + k);
      #1 rdy = bus_if.late_ready[0];
      step();
      if (rdy) k++;
      check_eq("busy_main_we",   bus_if.wb_rf_r_we,   1);
      check_eq("busy_main_data", bus_if.wb_rf_r,      32'h100 + c);
    end
    check_eq("full_accepts", k, 4);
    check_eq("full_ready",   bus_if.late_ready, 2'b00);
    check_eq("full_busy",    bus_if.wb_late_busy, 1);

    set_main(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    j = 0;
    for (int c = 0; c < 20 && j < 5; c++) begin
      set_late(0, k < 5, 5'(10 + k), 32'h50 + k);
      #1 rdy = bus_if.late_ready[0];
      step();
      if (rdy) k++;
      if (bus_if.wb_rf_r_we) begin
        check_eq("drain_addr", bus_if.wb_rf_r_addr, 10 + j);
        check_eq("drain_data", bus_if.wb_rf_r,      32'h50 + j);
        j++;
      end
    end
    set_late(0, 1'b0, 5'd0, 32'h0);
    check_eq("drain_count",   j, 5);
    check_eq("drain_accepts", k, 5);
    check_eq("drain_busy",    bus_if.wb_late_busy, 0);

    // Two buffered entries flushed by an exception
    set_main(1'b0, 1'b1, 5'd9, 1'b0, 32'h200, 32'h0);
    set_late(1, 1'b1, 5'd20, 32'h77);
    #1 check_eq("exc_fill_ready", bus_if.late_ready, 2'b10);
    step();
    set_late(1, 1'b1, 5'd21, 32'h88);
    #1 step();
    set_late(1, 1'b0, 5'd0, 32'h0);
    check_eq("exc_fill_busy", bus_if.wb_late_busy, 1);
    bus_if.do_exception = 1'b1;
    bus_if.mem_pc       = 32'h100;
    set_late(0, 1'b1, 5'd22, 32'h99);
    #1 check_eq("exc_ready", bus_if.late_ready, 2'b00);
    step();
    check_eq("exc_we",   bus_if.wb_rf_r_we,   1);
    check_eq("exc_addr", bus_if.wb_rf_r_addr, 30);
    check_eq("exc_data", bus_if.wb_rf_r,      32'h100);
    check_eq("exc_busy", bus_if.wb_late_busy, 0);
    bus_if.do_exception = 1'b0;
    set_late(0, 1'b0, 5'd0, 32'h0);
    set_main(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("flushed_no_we", bus_if.wb_rf_r_we, 0);
    end
    check_eq("exc_retired", bus_if.wb_retired, exp_ret);

    // r0 from both main and late: no write, handshake still completes
    set_main(1'b0, 1'b1, 5'd0, 1'b0, 32'h5555, 32'h0);
    set_late(0, 1'b1, 5'd0, 32'h66);
    #1 check_eq("r0_ready", bus_if.late_ready, 2'b01);
    step();
    check_eq("r0_main_we", bus_if.wb_rf_r_we, 0);
    set_late(0, 1'b0, 5'd0, 32'h0);
    set_main(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    check_eq("r0_busy", bus_if.wb_late_busy, 0);
    step();
    check_eq("r0_late_we", bus_if.wb_rf_r_we, 0);
    check_eq("r0_retired", bus_if.wb_retired, exp_ret);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
